// File: rtl/id_ex_register_if.sv
// rtl/id_ex_register_if.sv - ID-side and EX-side pipeline signal bundle for the ID/EX register
interface id_ex_register_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ID_Valid_i;
    logic                  ID_RegDst_i;
    logic                  ID_BranchEQ_i;
    logic                  ID_BranchNE_i;
    logic                  ID_MemRead_i;
    logic                  ID_MemtoReg_i;
    logic                  ID_MemWrite_i;
    logic                  ID_ALUSrc_i;
    logic                  ID_RegWrite_i;
    logic [2:0]            ID_ALUOp_i;
    logic [DATA_WIDTH-1:0] ID_PC4_i;
    logic [DATA_WIDTH-1:0] ID_ReadData1_i;
    logic [DATA_WIDTH-1:0] ID_ReadData2_i;
    logic [DATA_WIDTH-1:0] ID_Imm_i;
    logic [4:0]            ID_Rs_i;
    logic [4:0]            ID_Rt_i;
    logic [4:0]            ID_Rd_i;

    logic                  EX_Valid_o;
    logic                  EX_RegDst_o;
    logic                  EX_BranchEQ_o;
    logic                  EX_BranchNE_o;
    logic                  EX_MemRead_o;
    logic                  EX_MemtoReg_o;
    logic                  EX_MemWrite_o;
    logic                  EX_ALUSrc_o;
    logic                  EX_RegWrite_o;
    logic [2:0]            EX_ALUOp_o;
    logic [DATA_WIDTH-1:0] EX_PC4_o;
    logic [DATA_WIDTH-1:0] EX_ReadData1_o;
    logic [DATA_WIDTH-1:0] EX_ReadData2_o;
    logic [DATA_WIDTH-1:0] EX_Imm_o;
    logic [4:0]            EX_Rs_o;
    logic [4:0]            EX_Rt_o;
    logic [4:0]            EX_Rd_o;

    modport master (
        output ID_Valid_i, ID_RegDst_i, ID_BranchEQ_i, ID_BranchNE_i, ID_MemRead_i,
               ID_MemtoReg_i, ID_MemWrite_i, ID_ALUSrc_i, ID_RegWrite_i, ID_ALUOp_i,
               ID_PC4_i, ID_ReadData1_i, ID_ReadData2_i, ID_Imm_i, ID_Rs_i, ID_Rt_i, ID_Rd_i,
        input  EX_Valid_o, EX_RegDst_o, EX_BranchEQ_o, EX_BranchNE_o, EX_MemRead_o,
               EX_MemtoReg_o, EX_MemWrite_o, EX_ALUSrc_o, EX_RegWrite_o, EX_ALUOp_o,
               EX_PC4_o, EX_ReadData1_o, EX_ReadData2_o, EX_Imm_o, EX_Rs_o, EX_Rt_o, EX_Rd_o
    );

    modport slave (
        input  ID_Valid_i, ID_RegDst_i, ID_BranchEQ_i, ID_BranchNE_i, ID_MemRead_i,
               ID_MemtoReg_i, ID_MemWrite_i, ID_ALUSrc_i, ID_RegWrite_i, ID_ALUOp_i,
               ID_PC4_i, ID_ReadData1_i, ID_ReadData2_i, ID_Imm_i, ID_Rs_i, ID_Rt_i, ID_Rd_i,
        output EX_Valid_o, EX_RegDst_o, EX_BranchEQ_o, EX_BranchNE_o, EX_MemRead_o,
               EX_MemtoReg_o, EX_MemWrite_o, EX_ALUSrc_o, EX_RegWrite_o, EX_ALUOp_o,
               EX_PC4_o, EX_ReadData1_o, EX_ReadData2_o, EX_Imm_o, EX_Rs_o, EX_Rt_o, EX_Rd_o
    );
endinterface

// File: rtl/id_ex_register.sv
// rtl/id_ex_register.sv - ID/EX pipeline register with load-use stall detection and bubble counter
module id_ex_register #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Flush_i,
    output logic                 Stall_o,
    output logic [CNT_WIDTH-1:0] BubbleCount_o,
    id_ex_register_if.slave      bus
);
    // Control vector layout: {RegDst, BranchEQ, BranchNE, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp[2:0]}
    localparam int CW          = 11;
    localparam int MEMREAD_BIT = 7;

    logic [CW-1:0]         id_ctrl;
    logic [CW-1:0]         ctrl_d, ctrl_q;
    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] pc4_d, pc4_q, rd1_d, rd1_q, rd2_d, rd2_q, imm_d, imm_q;
    logic [4:0]            rs_d, rs_q, rt_d, rt_q, rd_d, rd_q;
    logic [CNT_WIDTH-1:0]  cnt_d, cnt_q;
    logic                  hazard;
    logic                  bubble;

    assign id_ctrl = {bus.ID_RegDst_i, bus.ID_BranchEQ_i, bus.ID_BranchNE_i, bus.ID_MemRead_i,
                      bus.ID_MemtoReg_i, bus.ID_MemWrite_i, bus.ID_ALUSrc_i, bus.ID_RegWrite_i,
                      bus.ID_ALUOp_i};

    // A bubble clears EX_MemRead, so the hazard cannot persist past one cycle.
    assign hazard = bus.ID_Valid_i & valid_q & ctrl_q[MEMREAD_BIT] & (rt_q != 5'd0) &
                    ((rt_q == bus.ID_Rs_i) | (rt_q == bus.ID_Rt_i));
    assign bubble = Flush_i | hazard;

    always_comb begin
        valid_d = bus.ID_Valid_i;
        ctrl_d  = id_ctrl;
        pc4_d   = bus.ID_PC4_i;
        rd1_d   = bus.ID_ReadData1_i;
        rd2_d   = bus.ID_ReadData2_i;
        imm_d   = bus.ID_Imm_i;
        rs_d    = bus.ID_Rs_i;
        rt_d    = bus.ID_Rt_i;
        rd_d    = bus.ID_Rd_i;
        cnt_d   = cnt_q;
        if (bubble) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            if (bus.ID_Valid_i && (cnt_q != '1)) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            pc4_q   <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            pc4_q   <= pc4_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.EX_Valid_o     = valid_q;
    assign bus.EX_RegDst_o    = ctrl_q[10];
    assign bus.EX_BranchEQ_o  = ctrl_q[9];
    assign bus.EX_BranchNE_o  = ctrl_q[8];
    assign bus.EX_MemRead_o   = ctrl_q[7];
    assign bus.EX_MemtoReg_o  = ctrl_q[6];
    assign bus.EX_MemWrite_o  = ctrl_q[5];
    assign bus.EX_ALUSrc_o    = ctrl_q[4];
    assign bus.EX_RegWrite_o  = ctrl_q[3];
    assign bus.EX_ALUOp_o     = ctrl_q[2:0];
    assign bus.EX_PC4_o       = pc4_q;
    assign bus.EX_ReadData1_o = rd1_q;
    assign bus.EX_ReadData2_o = rd2_q;
    assign bus.EX_Imm_o       = imm_q;
    assign bus.EX_Rs_o        = rs_q;
    assign bus.EX_Rt_o        = rt_q;
    assign bus.EX_Rd_o        = rd_q;
    assign Stall_o            = hazard;
    assign BubbleCount_o      = cnt_q;
endmodule

// File: tb/tb_id_ex_register.sv
// tb/tb_id_ex_register.sv - directed self-checking bench for id_ex_register
module tb_id_ex_register;
    localparam int DW = 32;
    localparam int CNTW = 3;

    localparam logic [10:0] C_NONE  = 11'b000_0000_0000;
    localparam logic [10:0] C_ADDI  = 11'b000_0001_1100;
    localparam logic [10:0] C_LW    = 11'b000_1101_1000;
    localparam logic [10:0] C_RTYPE = 11'b100_0000_1111;

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            stall;
    logic [CNTW-1:0] bcnt;
    int              checks = 0;
    int              errors = 0;

    id_ex_register_if #(.DATA_WIDTH(DW)) bus ();

    id_ex_register #(.DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) dut (
        .clk           (clk),
        .reset         (reset),
        .Flush_i       (flush),
        .Stall_o       (stall),
        .BubbleCount_o (bcnt),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] ex_ctrl();
        return {bus.EX_RegDst_o, bus.EX_BranchEQ_o, bus.EX_BranchNE_o, bus.EX_MemRead_o,
                bus.EX_MemtoReg_o, bus.EX_MemWrite_o, bus.EX_ALUSrc_o, bus.EX_RegWrite_o,
                bus.EX_ALUOp_o};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [10:0] c, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] imm);
        bus.ID_Valid_i     = v;
        bus.ID_RegDst_i    = c[10];
        bus.ID_BranchEQ_i  = c[9];
        bus.ID_BranchNE_i  = c[8];
        bus.ID_MemRead_i   = c[7];
        bus.ID_MemtoReg_i  = c[6];
        bus.ID_MemWrite_i  = c[5];
        bus.ID_ALUSrc_i    = c[4];
        bus.ID_RegWrite_i  = c[3];
        bus.ID_ALUOp_i     = c[2:0];
        bus.ID_PC4_i       = 32'h0000_1000 + imm;
        bus.ID_ReadData1_i = 32'hA000_0000 | {27'd0, rs};
        bus.ID_ReadData2_i = 32'hB000_0000 | {27'd0, rt};
        bus.ID_Imm_i       = imm;
        bus.ID_Rs_i        = rs;
        bus.ID_Rt_i        = rt;
        bus.ID_Rd_i        = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        set_id(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h77);
        #2;
        chk("rst_valid", bus.EX_Valid_o, 1'b0);
        chk("rst_ctrl", ex_ctrl(), C_NONE);
        chk("rst_cnt", bcnt, 3'd0);
        chk("rst_stall", stall, 1'b0);
        step();
        chk("rst_edge_nocap", bus.EX_Valid_o, 1'b0);
        reset = 1'b0;

        // ADDI capture
        set_id(1'b1, C_ADDI, 5'd1, 5'd9, 5'd0, 32'h0000_0005);
        step();
        chk("addi_valid", bus.EX_Valid_o, 1'b1);
        chk("addi_ctrl", ex_ctrl(), C_ADDI);
        chk("addi_imm", bus.EX_Imm_o, 32'h5);
        chk("addi_rt", bus.EX_Rt_o, 5'd9);
        chk("addi_pc4", bus.EX_PC4_o, 32'h1005);
        chk("addi_stall", stall, 1'b0);

        // Load-use hazard
        set_id(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 32'h10);
        step();
        chk("lw_memread", bus.EX_MemRead_o, 1'b1);
        set_id(1'b1, C_RTYPE, 5'd8, 5'd3, 5'd10, 32'h0);
        #1;
        chk("lu_stall", stall, 1'b1);
        step();
        chk("lu_bub_valid", bus.EX_Valid_o, 1'b0);
        chk("lu_bub_ctrl", ex_ctrl(), C_NONE);
        chk("lu_bub_rd", bus.EX_Rd_o, 5'd10);
        chk("lu_bub_rd1", bus.EX_ReadData1_o, 32'hA000_0008);
        chk("lu_cnt", bcnt, 3'd1);
        chk("lu_stall_drop", stall, 1'b0);
        step();
        chk("lu_cap_valid", bus.EX_Valid_o, 1'b1);
        chk("lu_cap_ctrl", ex_ctrl(), C_RTYPE);
        chk("lu_cap_cnt", bcnt, 3'd1);

        // No false hazard: Rt=0, then MemRead=0
        set_id(1'b1, C_LW, 5'd4, 5'd0, 5'd0, 32'h0);
        step();
        set_id(1'b1, C_RTYPE, 5'd0, 5'd0, 5'd6, 32'h0);
        #1;
        chk("nf_rt0", stall, 1'b0);
        set_id(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd5, 32'h0);
        step();
        bus.ID_Rs_i = 5'd5;
        #1;
        chk("nf_nomemread", stall, 1'b0);

        // Flush of valid R-type
        set_id(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd17, 32'h0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_regwrite", bus.EX_RegWrite_o, 1'b0);
        chk("fl_valid", bus.EX_Valid_o, 1'b0);
        chk("fl_rd", bus.EX_Rd_o, 5'd17);
        chk("fl_cnt", bcnt, 3'd2);

        // Flush and stall together
        set_id(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 32'h0);
        step();
        set_id(1'b1, C_RTYPE, 5'd8, 5'd3, 5'd11, 32'h0);
        flush = 1'b1;
        #1;
        chk("fs_stall", stall, 1'b1);
        step();
        flush = 1'b0;
        chk("fs_valid", bus.EX_Valid_o, 1'b0);
        chk("fs_cnt", bcnt, 3'd3);

        // Invalid ID without bubble, then flush of invalid ID
        set_id(1'b0, C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h0);
        step();
        chk("inv_valid", bus.EX_Valid_o, 1'b0);
        chk("inv_ctrl", ex_ctrl(), C_RTYPE);
        chk("inv_cnt", bcnt, 3'd3);
        flush = 1'b1;
        step();
        chk("inv_fl_ctrl", ex_ctrl(), C_NONE);
        chk("inv_fl_cnt", bcnt, 3'd3);

        // Saturation at all-ones
        set_id(1'b1, C_RTYPE, 5'd1, 5'd2, 5'd3, 32'h0);
        for (int i = 0; i < 4; i++) step();
        chk("sat_reach", bcnt, 3'd7);
        step();
        chk("sat_hold", bcnt, 3'd7);
        flush = 1'b0;

        // Async reset mid-operation
        set_id(1'b1, C_ADDI, 5'd1, 5'd9, 5'd0, 32'h5);
        step();
        chk("ar_pre_valid", bus.EX_Valid_o, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_valid", bus.EX_Valid_o, 1'b0);
        chk("ar_ctrl", ex_ctrl(), C_NONE);
        chk("ar_cnt", bcnt, 3'd0);
        step();
        reset = 1'b0;

        // Reset mid-stall discards bubble
        set_id(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 32'h0);
        step();
        set_id(1'b1, C_RTYPE, 5'd8, 5'd3, 5'd12, 32'h0);
        #1;
        chk("rs_stall", stall, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk("rs_stall_clr", stall, 1'b0);
        step();
        chk("rs_edge_nocap", bus.EX_Valid_o, 1'b0);
        reset = 1'b0;
        step();
        chk("rs_cap_valid", bus.EX_Valid_o, 1'b1);
        chk("rs_cap_ctrl", ex_ctrl(), C_RTYPE);
        chk("rs_cap_rd", bus.EX_Rd_o, 5'd12);
        chk("rs_cap_cnt", bcnt, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_ex_register.md
ID_EX_REGISTER -- requirements
Module: id_ex_register

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of PC+4, register-read and immediate datapaths.
REQ-002 Parameter: CNT_WIDTH, 16, width of bubble counter.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: Flush_i  input  1  branch-taken kill of the instruction now in ID.
REQ-006 Port: ID_Valid_i  input  1  ID stage holds a real instruction.
REQ-007 Port: ID_RegDst_i, ID_BranchEQ_i, ID_BranchNE_i, ID_MemRead_i, ID_MemtoReg_i, ID_MemWrite_i, ID_ALUSrc_i, ID_RegWrite_i  input  1 each  decoder control signals.
REQ-008 Port: ID_ALUOp_i  input  3  decoder ALU operation class.
REQ-009 Port: ID_PC4_i, ID_ReadData1_i, ID_ReadData2_i, ID_Imm_i  input  DATA_WIDTH each  ID datapath values (Imm already sign-extended).
REQ-010 Port: ID_Rs_i, ID_Rt_i, ID_Rd_i  input  5 each  register specifiers.
REQ-011 Port: EX_* outputs  output  same widths as REQ-007..REQ-010  registered copies (EX_RegDst_o ... EX_Rd_o).
REQ-012 Port: EX_Valid_o  output  1  EX stage holds a real instruction.
REQ-013 Port: Stall_o  output  1  load-use hazard; PC and IF/ID must hold this cycle.
REQ-014 Port: BubbleCount_o  output  CNT_WIDTH  number of bubbles inserted since reset.

Function
REQ-015 Stall_o SHALL be combinational: ID_Valid_i & EX_Valid_o & EX_MemRead_o & (EX_Rt_o != 0) & ((EX_Rt_o == ID_Rs_i) | (EX_Rt_o == ID_Rt_i)).
REQ-016 Normal capture (no reset, Flush_i=0, Stall_o=0): all EX_* outputs SHALL take the ID_* inputs on the rising edge; EX_Valid_o takes ID_Valid_i; latency one cycle.
REQ-017 Bubble (Flush_i=1 or Stall_o=1): EX_Valid_o and all nine control outputs (eight 1-bit plus EX_ALUOp_o) SHALL be loaded with 0; datapath and specifier outputs SHALL still capture ID_* values.
REQ-018 Priority SHALL be reset > bubble > normal capture; Flush_i and Stall_o together produce one bubble, counted once.
REQ-019 A stall SHALL last exactly one cycle per load: after the bubble EX_MemRead_o=0, so Stall_o deasserts with unchanged ID inputs.
REQ-020 ID_Valid_i=0 with no bubble condition SHALL be captured as normal (EX_Valid_o=0, controls copied) and SHALL NOT increment BubbleCount_o.
REQ-021 BubbleCount_o SHALL increment by 1 on each edge where a bubble is inserted and ID_Valid_i=1; SHALL saturate at all-ones (no wrap).
REQ-022 Downstream consumers SHALL qualify EX_RegWrite_o, EX_MemWrite_o, EX_MemRead_o with EX_Valid_o; this block guarantees those are 0 whenever EX_Valid_o=0 after a bubble or reset.
REQ-023 No internal state beyond the EX_* registers, EX_Valid_o and the counter.

Reset
REQ-024 On reset assertion, immediately and independent of clk: all EX_* outputs, EX_Valid_o and BubbleCount_o SHALL be 0; Stall_o thereby 0.
REQ-025 Reset asserted mid-stall SHALL discard the pending bubble; first edge after deassertion performs normal capture of current ID inputs.
REQ-026 Reset deassertion SHALL take effect on the next rising edge; no capture on the deasserting edge itself if reset still high at that edge.

Verification
REQ-027 ADDI capture: ID_Valid=1, RegDst=0, ALUSrc=1, RegWrite=1, ALUOp=3'b100, Imm=32'h0000_0005, Rt=9 -> next edge EX_* equal those values, EX_Valid=1, Stall_o=0.
REQ-028 Load-use: EX holds valid MemRead=1, Rt=8; ID valid with Rs=8 -> Stall_o=1; next edge EX_Valid=0, all controls 0, BubbleCount +1; following cycle Stall_o=0 and ID instruction captured.
REQ-029 No false hazard: EX MemRead=1, Rt=0, ID Rs=0 -> Stall_o=0; also EX MemRead=0, Rt=ID Rs -> Stall_o=0.
REQ-030 Flush: Flush_i=1 with valid R-type in ID (RegDst=1, RegWrite=1, ALUOp=3'b111) -> next edge EX_RegWrite=0, EX_Valid=0, EX_Rd equals ID Rd, BubbleCount +1.
REQ-031 Simultaneous Flush_i=1 and Stall_o=1 -> single bubble, BubbleCount +1 only.
REQ-032 Async reset mid-operation: assert reset between edges with EX_Valid=1 -> outputs and BubbleCount 0 before next edge; preload counter to all-ones via bubbles (or force) then bubble -> stays all-ones.
